multicycle_control_unit: RTL and testbench

//  Multi-cycle MIPS control FSM, the successor to the single-cycle decoder pair.

---
 rtl/mips_pkg.sv | 49 ++++
 rtl/alu_func_decoder.sv | 24 ++
 rtl/multicycle_control_unit.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, funct codes,
// ALU selects, FSM state codes and datapath mux codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_ADDIEX = 4'd8;
  localparam logic [3:0] S_ADDIWB = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JR     = 4'd12;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] B_RT     = 2'b00;
  localparam logic [1:0] B_FOUR   = 2'b01;
  localparam logic [1:0] B_IMM    = 2'b10;
  localparam logic [1:0] B_IMM_SH = 2'b11;

endpackage

// File: rtl/alu_func_decoder.sv
// R-type funct to ALU select; valid=0 marks a funct the ALU cannot execute.
module alu_func_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alusel,
  output logic       valid
);

  // funct lookup; unknown codes default to add but are flagged invalid
  always_comb begin
    alusel = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alusel = ALU_ADD;
      FN_SUB:  alusel = ALU_SUB;
      FN_AND:  alusel = ALU_AND;
      FN_OR:   alusel = ALU_OR;
      FN_SLT:  alusel = ALU_SLT;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM with a memory handshake, wait timeout and
// per-state datapath enables.
module multicycle_control_unit
  import mips_pkg::*;
#(
  parameter int ALUSEL_W  = 3,
  parameter int TIMEOUT_W = 4,
  parameter int EN_JR     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_we,
  output logic                pc_en,
  output logic [1:0]          pc_src,
  output logic                rf_we,
  output logic                rf_dsel,
  output logic                mtorf_sel,
  output logic                alu_a_sel,
  output logic [1:0]          alu_b_sel,
  output logic [ALUSEL_W-1:0] alusel,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                bus_err
);

  localparam logic [TIMEOUT_W-1:0] WAIT_ONE  = TIMEOUT_W'(32'd1);
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'((32'd1 << TIMEOUT_W) - 32'd2);

  logic [3:0]           state_r;
  logic [3:0]           state_nxt_s;
  logic [TIMEOUT_W-1:0] wait_cnt_r;
  logic                 bus_err_r;
  logic [2:0]           fn_alusel_s;
  logic                 fn_valid_s;
  logic                 jr_ok_s;
  logic                 mem_state_s;
  logic                 timeout_s;
  logic                 illegal_s;
  logic [2:0]           alu_code_s;

  alu_func_decoder u_alu_func_decoder (
    .funct  (funct),
    .alusel (fn_alusel_s),
    .valid  (fn_valid_s)
  );

  assign jr_ok_s     = (EN_JR != 32'd0) && (funct == FN_JR);
  assign mem_state_s = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
  // the final stalled cycle is the one that trips the timeout
  assign timeout_s   = mem_state_s && !mem_ready && (wait_cnt_r == WAIT_LAST);
  assign bus_err     = bus_err_r;
  assign alusel      = ALUSEL_W'(alu_code_s);

  // next-state selection and illegal-instruction detection
  always_comb begin
    state_nxt_s = S_FETCH;
    illegal_s   = 1'b0;
    case (state_r)
      S_FETCH:  if (mem_ready) state_nxt_s = S_DECODE; else state_nxt_s = S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt_s = S_MEMADR;
          OP_RTYPE: begin
            if (jr_ok_s)         state_nxt_s = S_JR;
            else if (fn_valid_s) state_nxt_s = S_EXEC;
            else                 illegal_s   = 1'b1;
          end
          OP_BEQ:  state_nxt_s = S_BRANCH;
          OP_ADDI: state_nxt_s = S_ADDIEX;
          OP_J:    state_nxt_s = S_JUMP;
          default: illegal_s   = 1'b1;
        endcase
      end
      S_MEMADR: if (opcode == OP_LW) state_nxt_s = S_MEMRD; else state_nxt_s = S_MEMWR;
      S_MEMRD: begin
        if (timeout_s)      state_nxt_s = S_FETCH;
        else if (mem_ready) state_nxt_s = S_MEMWB;
        else                state_nxt_s = S_MEMRD;
      end
      S_MEMWR:  if (mem_ready || timeout_s) state_nxt_s = S_FETCH; else state_nxt_s = S_MEMWR;
      S_EXEC:   state_nxt_s = S_ALUWB;
      S_ADDIEX: state_nxt_s = S_ADDIWB;
      default:  state_nxt_s = S_FETCH;
    endcase
  end

  // per-state datapath controls; FETCH/MEMWR/BRANCH also look at mem_ready or zero
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PC_ALU;
    rf_we      = 1'b0;
    rf_dsel    = 1'b0;
    mtorf_sel  = 1'b0;
    alu_a_sel  = 1'b0;
    alu_b_sel  = B_RT;
    alu_code_s = ALU_ADD;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_b_sel = B_FOUR;
        ir_we     = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_b_sel  = B_IMM_SH;
        illegal_op = illegal_s;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_a_sel = 1'b1;
        alu_b_sel = B_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        rf_we      = 1'b1;
        mtorf_sel  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_a_sel  = 1'b1;
        alu_code_s = fn_alusel_s;
      end
      S_ALUWB: begin
        rf_we      = 1'b1;
        rf_dsel    = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIWB: begin
        rf_we      = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_a_sel  = 1'b1;
        alu_code_s = ALU_SUB;
        pc_src     = PC_ALUOUT;
        pc_en      = zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = PC_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      S_JR: begin
        pc_src     = PC_RS;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_FETCH;
    else        state_r <= state_nxt_s;
  end

  // memory wait counter; any exit from a stall (ready, timeout, non-memory state) clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     wait_cnt_r <= '0;
    else if (!mem_state_s || mem_ready || timeout_s) wait_cnt_r <= '0;
    else                                            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
  end

  // sticky bus error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         bus_err_r <= 1'b0;
    else if (timeout_s) bus_err_r <= 1'b1;
    else                bus_err_r <= bus_err_r;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction table, hand-written corner
// sequences and random instructions checked against a per-instruction cycle planner.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic m_mem_req, m_mem_we, m_iord, m_ir_we, m_pc_en, m_rf_we, m_rf_dsel, m_mtorf_sel;
  logic m_alu_a_sel, m_instr_done, m_illegal_op, m_bus_err;
  logic [1:0] m_pc_src, m_alu_b_sel;
  logic [2:0] m_alusel;
  logic a_mem_req, a_mem_we, a_iord, a_ir_we, a_pc_en, a_rf_we, a_rf_dsel, a_mtorf_sel;
  logic a_alu_a_sel, a_instr_done, a_illegal_op, a_bus_err;
  logic [1:0] a_pc_src, a_alu_b_sel;
  logic [2:0] a_alusel;

  int n_vec = 0;
  int n_err = 0;
  int mw_seen, rf_seen;

  always #5 clk = ~clk;

  multicycle_control_unit u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(m_mem_req), .mem_we(m_mem_we), .iord(m_iord), .ir_we(m_ir_we), .pc_en(m_pc_en),
    .pc_src(m_pc_src), .rf_we(m_rf_we), .rf_dsel(m_rf_dsel), .mtorf_sel(m_mtorf_sel),
    .alu_a_sel(m_alu_a_sel), .alu_b_sel(m_alu_b_sel), .alusel(m_alusel),
    .instr_done(m_instr_done), .illegal_op(m_illegal_op), .bus_err(m_bus_err)
  );

  multicycle_control_unit #(.ALUSEL_W(3), .TIMEOUT_W(2), .EN_JR(0)) u_alt (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .iord(a_iord), .ir_we(a_ir_we), .pc_en(a_pc_en),
    .pc_src(a_pc_src), .rf_we(a_rf_we), .rf_dsel(a_rf_dsel), .mtorf_sel(a_mtorf_sel),
    .alu_a_sel(a_alu_a_sel), .alu_b_sel(a_alu_b_sel), .alusel(a_alusel),
    .instr_done(a_instr_done), .illegal_op(a_illegal_op), .bus_err(a_bus_err)
  );

  localparam int P_REQ = 17, P_MWE = 16, P_IORD = 15, P_IRWE = 14, P_PCEN = 13, P_PCSRC = 11;
  localparam int P_RFWE = 10, P_DSEL = 9, P_MTORF = 8, P_ASEL = 7, P_BSEL = 5, P_ALU = 2;
  localparam int P_DONE = 1, P_ILL = 0;

  typedef struct {
    logic [17:0] val;
    logic [17:0] care;
    logic        rdy;
    logic        zro;
  } cyc_t;

  cyc_t plan_q[$];

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         cyc;
    int         rf;
    int         mw;
    int         pcen;
    int         ill;
  } row_t;

  row_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cyc_t setf(cyc_t c, int pos, int w, logic [2:0] v);
    for (int i = 0; i < w; i++) begin
      c.val[pos+i]  = v[i];
      c.care[pos+i] = 1'b1;
    end
    return c;
  endfunction

  // a cycle where every enable and pulse is expected low; selects are don't-care
  function automatic cyc_t blank(logic rdy);
    cyc_t c;
    c.val  = '0;
    c.care = '0;
    c.rdy  = rdy;
    c.zro  = 1'($urandom_range(0, 1));
    c.care[P_REQ] = 1'b1;  c.care[P_MWE] = 1'b1;  c.care[P_IRWE] = 1'b1; c.care[P_PCEN] = 1'b1;
    c.care[P_RFWE] = 1'b1; c.care[P_DONE] = 1'b1; c.care[P_ILL] = 1'b1;
    return c;
  endfunction

  function automatic cyc_t fetch_cyc(logic rdy);
    cyc_t c = blank(rdy);
    c = setf(c, P_REQ, 1, 3'd1);  c = setf(c, P_IORD, 1, 3'd0);
    c = setf(c, P_ASEL, 1, 3'd0); c = setf(c, P_BSEL, 2, 3'd1); c = setf(c, P_ALU, 3, 3'b010);
    if (rdy) begin
      c = setf(c, P_IRWE, 1, 3'd1); c = setf(c, P_PCEN, 1, 3'd1); c = setf(c, P_PCSRC, 2, 3'd0);
    end
    return c;
  endfunction

  function automatic cyc_t mem_cyc(logic rdy, logic wr);
    cyc_t c = blank(rdy);
    c = setf(c, P_REQ, 1, 3'd1); c = setf(c, P_IORD, 1, 3'd1); c = setf(c, P_MWE, 1, {2'b00, wr});
    c = setf(c, P_DONE, 1, {2'b00, wr & rdy});
    return c;
  endfunction

  function automatic logic [3:0] ref_alu(logic [5:0] fn);
    case (fn)
      6'h20:   return 4'b1010;
      6'h22:   return 4'b1110;
      6'h24:   return 4'b1000;
      6'h25:   return 4'b1001;
      6'h2A:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Expected cycle sequence of one instruction: lf fetch stalls, lm data-memory stalls.
  task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int lf, input int lm, input bit en_jr);
    cyc_t c;
    logic [3:0] al;
    bit is_jr, legal;
    for (int i = 0; i < lf; i++) plan_q.push_back(fetch_cyc(1'b0));
    plan_q.push_back(fetch_cyc(1'b1));
    al    = ref_alu(fn);
    is_jr = en_jr && (op == 6'h00) && (fn == 6'h08);
    legal = (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h08) || (op == 6'h02) ||
            ((op == 6'h00) && (al[3] || is_jr));
    c = blank(1'($urandom_range(0, 1)));
    c = setf(c, P_ASEL, 1, 3'd0); c = setf(c, P_BSEL, 2, 3'd3); c = setf(c, P_ALU, 3, 3'b010);
    if (!legal) c = setf(c, P_ILL, 1, 3'd1);
    plan_q.push_back(c);
    if (!legal) return;
    c = blank(1'($urandom_range(0, 1)));
    if (op == 6'h23 || op == 6'h2B || op == 6'h08) begin
      c = setf(c, P_ASEL, 1, 3'd1); c = setf(c, P_BSEL, 2, 3'd2); c = setf(c, P_ALU, 3, 3'b010);
      plan_q.push_back(c);
      c = blank(1'($urandom_range(0, 1)));
      if (op == 6'h08) begin
        c = setf(c, P_RFWE, 1, 3'd1); c = setf(c, P_DSEL, 1, 3'd0); c = setf(c, P_MTORF, 1, 3'd0);
        c = setf(c, P_DONE, 1, 3'd1);
        plan_q.push_back(c);
      end else begin
        for (int i = 0; i < lm; i++) plan_q.push_back(mem_cyc(1'b0, op == 6'h2B));
        plan_q.push_back(mem_cyc(1'b1, op == 6'h2B));
        if (op == 6'h23) begin
          c = setf(c, P_RFWE, 1, 3'd1); c = setf(c, P_DSEL, 1, 3'd0); c = setf(c, P_MTORF, 1, 3'd1);
          c = setf(c, P_DONE, 1, 3'd1);
          plan_q.push_back(c);
        end
      end
    end else if (op == 6'h00 && !is_jr) begin
      c = setf(c, P_ASEL, 1, 3'd1); c = setf(c, P_BSEL, 2, 3'd0); c = setf(c, P_ALU, 3, al[2:0]);
      plan_q.push_back(c);
      c = blank(1'($urandom_range(0, 1)));
      c = setf(c, P_RFWE, 1, 3'd1); c = setf(c, P_DSEL, 1, 3'd1); c = setf(c, P_MTORF, 1, 3'd0);
      c = setf(c, P_DONE, 1, 3'd1);
      plan_q.push_back(c);
    end else begin
      c = setf(c, P_DONE, 1, 3'd1);
      if (op == 6'h04) begin
        c.zro = z;
        c = setf(c, P_ASEL, 1, 3'd1); c = setf(c, P_BSEL, 2, 3'd0); c = setf(c, P_ALU, 3, 3'b110);
        c = setf(c, P_PCSRC, 2, 3'd1); c = setf(c, P_PCEN, 1, {2'b00, z});
      end else begin
        c = setf(c, P_PCSRC, 2, (op == 6'h02) ? 3'd2 : 3'd3); c = setf(c, P_PCEN, 1, 3'd1);
      end
      plan_q.push_back(c);
    end
  endtask

  task automatic run_queue(input string tag);
    cyc_t c;
    logic [17:0] obs;
    while (plan_q.size() > 0) begin
      c = plan_q.pop_front();
      mem_ready = c.rdy;
      zero      = c.zro;
      @(negedge clk);
      obs = {m_mem_req, m_mem_we, m_iord, m_ir_we, m_pc_en, m_pc_src, m_rf_we, m_rf_dsel,
             m_mtorf_sel, m_alu_a_sel, m_alu_b_sel, m_alusel, m_instr_done, m_illegal_op};
      mw_seen += 32'(m_mem_we);
      rf_seen += 32'(m_rf_we);
      n_vec++;
      if (((obs ^ c.val) & c.care) != 18'd0) begin
        n_err++;
        $display("FAIL %s op=%h fn=%h: got %h expected %h (care %h)", tag, opcode, funct, obs, c.val, c.care);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 6'h00; funct = 6'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[8];
    logic [5:0] fns[8];
    int cyc, rf, mw, pe, il;
    bit fin, err_ok, pe_seen, req_ok;
    tbl[0]  = '{6'h23, 6'h00, 1'b0, 5, 1, 0, 1, 0};
    tbl[1]  = '{6'h2B, 6'h00, 1'b0, 4, 0, 1, 1, 0};
    tbl[2]  = '{6'h00, 6'h20, 1'b0, 4, 1, 0, 1, 0};
    tbl[3]  = '{6'h00, 6'h2A, 1'b0, 4, 1, 0, 1, 0};
    tbl[4]  = '{6'h08, 6'h00, 1'b0, 4, 1, 0, 1, 0};
    tbl[5]  = '{6'h04, 6'h00, 1'b1, 3, 0, 0, 2, 0};
    tbl[6]  = '{6'h04, 6'h00, 1'b0, 3, 0, 0, 1, 0};
    tbl[7]  = '{6'h02, 6'h00, 1'b0, 3, 0, 0, 2, 0};
    tbl[8]  = '{6'h00, 6'h08, 1'b0, 3, 0, 0, 2, 0};
    tbl[9]  = '{6'h3F, 6'h00, 1'b0, 2, 0, 0, 1, 1};
    tbl[10] = '{6'h00, 6'h30, 1'b0, 2, 0, 0, 1, 1};
    ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h30, 6'h11};

    // reset state, sampled while rst_n is still low
    rst_n = 1'b0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(m_mem_req), 32'd1);
    check("rst_iord", 32'(m_iord), 32'd0);
    check("rst_enables", 32'({m_mem_we, m_ir_we, m_pc_en, m_rf_we, m_instr_done, m_illegal_op}), 32'd0);
    check("rst_bus_err", 32'(m_bus_err), 32'd0);
    check("rst_alu_sels", 32'({m_alu_a_sel, m_alu_b_sel, m_alusel}), 32'b0_01_010);
    rst_n = 1'b1;

    // instruction table, memory always ready
    for (int r = 0; r < 11; r++) begin
      opcode = tbl[r].op; funct = tbl[r].fn; zero = tbl[r].z; mem_ready = 1'b1;
      cyc = 0; rf = 0; mw = 0; pe = 0; il = 0; fin = 1'b0;
      while (!fin && cyc < 20) begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) check($sformatf("tbl%0d_fetch", r), 32'({m_mem_req, m_iord}), 32'b10);
        rf += 32'(m_rf_we); mw += 32'(m_mem_we); pe += 32'(m_pc_en); il += 32'(m_illegal_op);
        if (r == 5 && m_pc_en && cyc == 3) check("beq_taken_pc_src", 32'(m_pc_src), 32'b01);
        fin = m_instr_done | m_illegal_op;
        @(posedge clk); #1;
      end
      check($sformatf("tbl%0d_cycles", r), 32'(cyc), 32'(tbl[r].cyc));
      check($sformatf("tbl%0d_rf_we", r), 32'(rf), 32'(tbl[r].rf));
      check($sformatf("tbl%0d_mem_we", r), 32'(mw), 32'(tbl[r].mw));
      check($sformatf("tbl%0d_pc_en", r), 32'(pe), 32'(tbl[r].pcen));
      check($sformatf("tbl%0d_illegal", r), 32'(il), 32'(tbl[r].ill));
    end

    // sw with MEMWR waiting 3 cycles for memory
    do_reset();
    opcode = 6'h2B; funct = 6'h00; mw_seen = 0; rf_seen = 0;
    plan_instr(6'h2B, 6'h00, 1'b0, 0, 3, 1'b1);
    run_queue("sw_delayed");
    check("sw_delayed_mem_we_cycles", 32'(mw_seen), 32'd4);
    check("sw_delayed_rf_we", 32'(rf_seen), 32'd0);

    // funct 08 on the EN_JR=0 instance is illegal; the default instance executes JR
    do_reset();
    opcode = 6'h00; funct = 6'h08; mem_ready = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    check("alt_jr_illegal", 32'(a_illegal_op), 32'd1);
    check("alt_jr_no_writes", 32'({a_rf_we, a_mem_we, a_pc_en}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("alt_jr_back_in_fetch", 32'({a_mem_req, a_iord, a_illegal_op}), 32'b100);
    check("main_jr_exec", 32'({m_pc_en, m_pc_src, m_instr_done}), 32'b1111);
    @(posedge clk); #1;

    // memory stuck not-ready in FETCH on the TIMEOUT_W=2 instance
    do_reset();
    mem_ready = 1'b0;
    err_ok = 1'b1; pe_seen = 1'b0; req_ok = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) check("alt_no_err_before_timeout", 32'(a_bus_err), 32'd0);
      if (k == 4) check("alt_bus_err_after_3_waits", 32'(a_bus_err), 32'd1);
      if (k > 4 && !a_bus_err) err_ok = 1'b0;
      if (a_pc_en) pe_seen = 1'b1;
      if (!(a_mem_req && !a_iord)) req_ok = 1'b0;
      @(posedge clk); #1;
    end
    check("alt_bus_err_sticky", 32'(err_ok), 32'd1);
    check("alt_timeout_no_pc_en", 32'(pe_seen), 32'd0);
    check("alt_timeout_stays_fetch", 32'(req_ok), 32'd1);
    check("main_no_timeout_yet", 32'(m_bus_err), 32'd0);
    do_reset();
    check("alt_bus_err_cleared_by_reset", 32'(a_bus_err), 32'd0);

    // random instructions against the planner
    for (int n = 0; n < 150; n++) begin
      opcode = ops[$urandom_range(0, 7)];
      funct  = fns[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) funct = 6'($urandom);
      plan_instr(opcode, funct, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4), 1'b1);
      run_queue("random");
    end
    check("random_no_bus_err", 32'(m_bus_err), 32'd0);

    // reset asserted while a store is waiting in MEMWR
    do_reset();
    opcode = 6'h2B; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    check("memwr_mem_we_before_reset", 32'(m_mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("memwr_mem_we_async_drop", 32'({m_mem_we, m_mem_req, m_iord}), 32'b010);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_no_writes", 32'({m_mem_we, m_ir_we, m_pc_en, m_rf_we}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
